// File: rtl/usb_unstuff.sv
// Receive-path stage after NRZI decode: strips SYNC, removes stuffed zeros,
// and flags SYNC / stuffing violations. All outputs are registered.
//
// state  | meaning
// IDLE   | line idle, waiting for the first SYNC zero
// SYNC   | counting SYNC zeros, waiting for the terminating one
// DATA   | passing payload bits, counting consecutive ones
// DROP   | next bit must be a stuffed zero and is discarded
// ERR    | packet is corrupt, bits ignored until EOP
module usb_unstuff #(
  parameter int MAX_ONES       = 6,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bstr_in,
  input  logic bstr_in_ready,
  input  logic in_done,
  output logic bstr_out,
  output logic bstr_out_ready,
  output logic out_done,
  output logic stuff_err,
  output logic sync_err
);

  localparam int CNT_MAX = (MAX_ONES > 7) ? MAX_ONES : 7;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_DROP,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_zcnt;
  logic [CW-1:0]   r_ocnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state        <= S_IDLE;
      r_zcnt         <= '0;
      r_ocnt         <= '0;
      bstr_out       <= 1'b0;
      bstr_out_ready <= 1'b0;
      out_done       <= 1'b0;
      stuff_err      <= 1'b0;
      sync_err       <= 1'b0;
    end else begin
      bstr_out       <= 1'b0;
      bstr_out_ready <= 1'b0;
      out_done       <= 1'b0;
      stuff_err      <= 1'b0;
      sync_err       <= 1'b0;
      // EOP wins over any bit presented in the same cycle
      if (in_done) begin
        r_zcnt  <= '0;
        r_ocnt  <= '0;
        r_state <= S_IDLE;
        case (r_state)
          S_SYNC:  sync_err <= 1'b1;
          S_DATA:  out_done <= 1'b1;
          S_DROP: begin
            stuff_err <= 1'b1;
            out_done  <= 1'b1;
          end
          S_ERR:   out_done <= 1'b1;
          default: ;
        endcase
      end else if (bstr_in_ready) begin
        case (r_state)
          S_IDLE: begin
            if (!bstr_in) begin
              r_zcnt  <= CW'(1);
              r_state <= S_SYNC;
            end
          end
          S_SYNC: begin
            if (!bstr_in) begin
              if (r_zcnt != CW'(7)) r_zcnt <= r_zcnt + CW'(1);
            end else if (r_zcnt >= CW'(SYNC_MIN_ZEROS)) begin
              r_ocnt  <= '0;
              r_state <= S_DATA;
            end else begin
              sync_err <= 1'b1;
              r_state  <= S_ERR;
            end
          end
          S_DATA: begin
            bstr_out       <= bstr_in;
            bstr_out_ready <= 1'b1;
            if (!bstr_in) begin
              r_ocnt <= '0;
            end else if (r_ocnt == CW'(MAX_ONES - 1)) begin
              r_ocnt  <= '0;
              r_state <= S_DROP;
            end else begin
              r_ocnt <= r_ocnt + CW'(1);
            end
          end
          S_DROP: begin
            if (!bstr_in) begin
              r_state <= S_DATA;
            end else begin
              stuff_err <= 1'b1;
              r_state   <= S_ERR;
            end
          end
          S_ERR:   ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_unstuff.md
Name: usb_unstuff

Overview:
- Stage directly downstream of the NRZI decoder in the USB receive path. Consumes its raw-bit stream: bstr_in, bstr_in_ready, in_done.
- Locates and strips the SYNC pattern, then removes stuffed zeros inserted after runs of MAX_ONES ones.
- Flags SYNC and bit-stuffing violations.
- Presents a clean payload bit stream with an end-of-packet pulse to the packet decoder (PID/CRC stage).

Parameters:
MAX_ONES, 6, consecutive ones after which the next bit is a stuffed zero.
SYNC_MIN_ZEROS, 5, minimum decoded zeros before the terminating 1 for a valid SYNC (tolerates hub-dropped SYNC bits).

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous active-low reset
bstr_in  input  1  decoded bit from NRZI stage; valid only when bstr_in_ready=1 and in_done=0
bstr_in_ready  input  1  bstr_in carries a valid bit this cycle
in_done  input  1  one-cycle EOP indication; may coincide with bstr_in_ready=1 (bit ignored)
bstr_out  output  1  unstuffed payload bit
bstr_out_ready  output  1  one-cycle strobe per emitted payload bit
out_done  output  1  one-cycle end-of-packet strobe
stuff_err  output  1  one-cycle pulse: stuffing violation
sync_err  output  1  one-cycle pulse: malformed or truncated SYNC

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports named clk, rst_b.
- Reset: all outputs 0, state IDLE, zero and ones counters 0.
- All outputs registered. A response to an input event appears exactly 1 cycle later.
- Input event priority:
  - in_done=1 is an EOP event; bstr_in and bstr_in_ready are ignored that cycle.
  - Otherwise bstr_in_ready=1 is a bit event.
  - Otherwise no event; state held.
- States:
  - IDLE:
    - bit 0 -> SYNC with zcnt=1.
    - bit 1 -> stay in IDLE (line idle/J).
    - EOP -> no outputs, stay.
  - SYNC:
    - bit 0 -> zcnt++, saturating at 7.
    - bit 1 with zcnt>=SYNC_MIN_ZEROS -> DATA, ocnt=0, no output for the SYNC bits.
    - bit 1 with zcnt<SYNC_MIN_ZEROS -> sync_err pulse, go to ERR.
    - EOP -> sync_err pulse, go to IDLE. No out_done.
  - DATA:
    - Every bit is emitted: bstr_out=bit, bstr_out_ready=1.
    - Bit 1 -> ocnt++. When ocnt reaches MAX_ONES -> DROP, ocnt=0.
    - Bit 0 -> ocnt=0.
    - EOP -> out_done pulse, go to IDLE.
  - DROP:
    - Bit 0 -> discarded (no bstr_out_ready), go to DATA.
    - Bit 1 -> stuff_err pulse, go to ERR.
    - EOP -> stuff_err and out_done pulse in the same cycle, go to IDLE.
  - ERR:
    - Bits ignored, no outputs.
    - EOP -> out_done pulse, go to IDLE.
- Ones counting starts only at the first payload bit. The SYNC-terminating 1 does not count toward MAX_ONES.
- Never more than one bstr_out_ready per input bit. bstr_out is held at 0 when bstr_out_ready=0.
- out_done and bstr_out_ready are never high in the same cycle.
- Counters are wide enough for max(MAX_ONES, 7) and never wrap.
- Reset asserted mid-packet: immediate return to reset values. No out_done emitted for the aborted packet.

Test Plan:
- Clean packet:
  - Stimulus: bits 0000000 1, payload 1,0,1,1,0,0,1,0, then in_done.
  - Required: 8 bstr_out_ready strobes carrying 10110010; out_done exactly 1 cycle after in_done; no error pulses.
- Stuff removal:
  - Stimulus: SYNC, then 1111110 1 0, then in_done.
  - Required: 8 strobes carrying 11111110 (stuffed 0 absent); no stuff_err.
- Stuff error:
  - Stimulus: SYNC, then 1111111 1 0, then in_done.
  - Required: 6 strobes of 1; stuff_err 1 cycle after the 7th 1; later bits ignored; out_done after in_done.
- Short SYNC:
  - Stimulus: 0001 then bits, then in_done.
  - Required: sync_err 1 cycle after the 1; zero strobes; out_done after in_done.
- EOP in DROP:
  - Stimulus: SYNC, 111111, then in_done with bstr_in_ready=1.
  - Required: 6 strobes; stuff_err and out_done in the same cycle; next packet decodes normally.
- Reset mid-packet:
  - Stimulus: rst_b low after 3 payload bits, then release and send a clean packet.
  - Required: all outputs 0 immediately; no out_done for the aborted packet; second packet correct.
